// File: rtl/new_task_sender_pkg.sv
// ============================================================================
// OmpSsManager -- shared new-task protocol constants (ack codes, dest ids)
// Rev 1.0
// ============================================================================
`default_nettype none

package OmpSsManager;

    localparam int TASK_SEQ_ID_L = 32;
    localparam int TASK_SEQ_ID_H = 39;

    localparam logic [7:0] ACK_REJECT = 8'h00;
    localparam logic [7:0] ACK_OK     = 8'h01;
    localparam logic [7:0] ACK_FINAL  = 8'h02;

    localparam logic [4:0] HWR_DEPS_ID  = 5'd18;
    localparam logic [4:0] HWR_SCHED_ID = 5'd19;

endpackage

`default_nettype wire

// File: rtl/new_task_sender.sv
// ============================================================================
// new_task_sender -- accelerator-side initiator: one request message out, one ack in
// Rev 1.0
// ============================================================================
`default_nettype none

module new_task_sender
    import OmpSsManager::*;
#(
    parameter int ACC_BITS = 4,
    parameter int ACC_ID   = 0,
    parameter int SEQ_BITS = TASK_SEQ_ID_H - TASK_SEQ_ID_L + 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                parent_valid,
    output logic                parent_ready,
    input  logic [63:0]         parent_tid,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_deps,
    input  logic [63:0]         req_header,
    input  logic                in_tvalid,
    output logic                in_tready,
    input  logic [63:0]         in_tdata,
    input  logic                in_tlast,
    output logic                outStream_tvalid,
    input  logic                outStream_tready,
    output logic [63:0]         outStream_tdata,
    output logic                outStream_tlast,
    output logic [ACC_BITS-1:0] outStream_tid,
    output logic [4:0]          outStream_tdest,
    input  logic                ack_tvalid,
    output logic                ack_tready,
    input  logic [63:0]         ack_tdata,
    input  logic                ack_tlast,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [7:0]          rsp_code,
    output logic                final_mode
);

    localparam int SEQ_FIELD_W = TASK_SEQ_ID_H - TASK_SEQ_ID_L + 1;
    localparam logic [ACC_BITS-1:0] C_ACC_ID = ACC_BITS'(ACC_ID);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HEADER   = 3'd1,
        PTID     = 3'd2,
        PAYLOAD  = 3'd3,
        WAIT_ACK = 3'd4,
        RESPOND  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SEQ_BITS-1:0]    r_seq;
    logic                   r_final;
    logic [63:0]            r_ptid;
    logic [63:0]            r_header;
    logic                   r_deps;
    logic [7:0]             r_ack_code;
    logic                   r_ack_first;
    logic [7:0]             r_rsp_code;

    logic                   w_idle;
    logic                   w_seq_sat;
    logic [7:0]             w_first_code;
    logic [SEQ_FIELD_W-1:0] w_seq_field;
    logic [63:0]            w_header_seq;
    logic                   w_unused;

    // Ready is held low while reset is asserted so nothing can be accepted then.
    assign w_idle       = (r_state == IDLE) && rstn;
    assign parent_ready = w_idle;
    // parent_valid wins; req_ready drops so a request is never seen as accepted
    assign req_ready    = w_idle && !parent_valid;

    assign w_seq_sat    = &r_seq;
    assign w_first_code = r_ack_first ? ack_tdata[7:0] : r_ack_code;

    assign outStream_tid   = C_ACC_ID;
    assign outStream_tdest = r_deps ? HWR_DEPS_ID : HWR_SCHED_ID;
    assign rsp_code        = r_rsp_code;
    assign final_mode      = r_final;

    assign w_unused = ^{ack_tdata[63:8], r_header[TASK_SEQ_ID_H:TASK_SEQ_ID_L]};

    always_comb begin
        w_seq_field                = '0;
        w_seq_field[SEQ_BITS-1:0]  = r_seq;
        w_header_seq               = r_header;
        w_header_seq[TASK_SEQ_ID_H:TASK_SEQ_ID_L] = w_seq_field;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        outStream_tvalid = 1'b0;
        outStream_tdata  = '0;
        outStream_tlast  = 1'b0;
        in_tready        = 1'b0;
        ack_tready       = 1'b0;
        rsp_valid        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!parent_valid && req_valid) begin
                    w_next = (r_final || w_seq_sat) ? RESPOND : HEADER;
                end
            end
            HEADER: begin
                outStream_tvalid = 1'b1;
                outStream_tdata  = w_header_seq;
                if (outStream_tready) w_next = PTID;
            end
            PTID: begin
                outStream_tvalid = 1'b1;
                outStream_tdata  = r_ptid;
                if (outStream_tready) w_next = PAYLOAD;
            end
            PAYLOAD: begin
                outStream_tvalid = in_tvalid;
                in_tready        = outStream_tready;
                outStream_tdata  = in_tdata;
                outStream_tlast  = in_tlast;
                if (in_tvalid && outStream_tready && in_tlast) w_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                ack_tready = 1'b1;
                if (ack_tvalid && ack_tlast) w_next = RESPOND;
            end
            RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_seq       <= '0;
            r_final     <= 1'b0;
            r_ptid      <= '0;
            r_header    <= '0;
            r_deps      <= 1'b0;
            r_ack_code  <= '0;
            r_ack_first <= 1'b0;
            r_rsp_code  <= ACK_REJECT;
        end else begin
            case (r_state)
                IDLE: begin
                    if (parent_valid) begin
                        r_ptid  <= parent_tid;
                        r_seq   <= '0;
                        r_final <= 1'b0;
                    end else if (req_valid) begin
                        r_deps      <= req_deps;
                        r_header    <= req_header;
                        r_ack_first <= 1'b1;
                        if (r_final) begin
                            r_rsp_code <= ACK_FINAL;
                        end else if (w_seq_sat) begin
                            r_rsp_code <= ACK_REJECT;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (ack_tvalid) begin
                        r_ack_first <= 1'b0;
                        if (r_ack_first) r_ack_code <= ack_tdata[7:0];
                        // Only the first beat's code counts; later beats are drained.
                        if (ack_tlast) begin
                            if (w_first_code == ACK_OK) begin
                                r_rsp_code <= ACK_OK;
                                if (!w_seq_sat) r_seq <= r_seq + 1'b1;
                            end else if (w_first_code == ACK_FINAL) begin
                                r_rsp_code <= ACK_FINAL;
                                r_final    <= 1'b1;
                            end else begin
                                r_rsp_code <= ACK_REJECT;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_new_task_sender.sv
// ============================================================================
// tb_new_task_sender -- randomized bench with a transaction-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_new_task_sender;
    import OmpSsManager::*;

    localparam int SEQ_BITS = 3;
    localparam int SEQ_MAX  = 7;
    localparam int ACC_BITS = 4;
    localparam int ACC_ID   = 5;
    localparam int LIMIT    = 300;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic parent_valid = 0, req_valid = 0, req_deps = 0;
    logic parent_ready, req_ready;
    logic [63:0] parent_tid = '0, req_header = '0, in_tdata = '0, ack_tdata = '0;
    logic in_tvalid = 0, in_tlast = 0, in_tready;
    logic outStream_tvalid, outStream_tready = 1'b1, outStream_tlast;
    logic [63:0] outStream_tdata;
    logic [ACC_BITS-1:0] outStream_tid;
    logic [4:0] outStream_tdest;
    logic ack_tvalid = 0, ack_tlast = 0, ack_tready;
    logic rsp_valid, rsp_ready = 0, final_mode;
    logic [7:0] rsp_code;

    new_task_sender #(.ACC_BITS(ACC_BITS), .ACC_ID(ACC_ID), .SEQ_BITS(SEQ_BITS)) dut (
        .clk(clk), .rstn(rstn),
        .parent_valid(parent_valid), .parent_ready(parent_ready), .parent_tid(parent_tid),
        .req_valid(req_valid), .req_ready(req_ready), .req_deps(req_deps), .req_header(req_header),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tlast(in_tlast),
        .outStream_tvalid(outStream_tvalid), .outStream_tready(outStream_tready),
        .outStream_tdata(outStream_tdata), .outStream_tlast(outStream_tlast),
        .outStream_tid(outStream_tid), .outStream_tdest(outStream_tdest),
        .ack_tvalid(ack_tvalid), .ack_tready(ack_tready), .ack_tdata(ack_tdata), .ack_tlast(ack_tlast),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code), .final_mode(final_mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: protocol-level state and expected traffic.
    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [4:0]  dest;
    } beat_t;

    int          m_seq = 0;
    bit          m_final = 0;
    logic [63:0] m_ptid = '0;
    beat_t       exp_beats[$];
    logic [7:0]  exp_rsp[$];
    logic [63:0] obs_data[$];
    logic        obs_last[$];
    logic [4:0]  obs_dest[$];
    logic [7:0]  obs_rsp[$];
    bit          rnd_ready = 0;

    function automatic logic [63:0] hdr_with_seq(input logic [63:0] h, input int s);
        logic [63:0] mask;
        mask = ((64'd1 << (TASK_SEQ_ID_H - TASK_SEQ_ID_L + 1)) - 64'd1) << TASK_SEQ_ID_L;
        return (h & ~mask) | (64'(s) << TASK_SEQ_ID_L);
    endfunction

    // Compare process: every transferred beat / response against the model.
    logic        prev_hold = 0;
    logic [63:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk("tvalid_stable", outStream_tvalid, 1'b1);
                chk("tdata_stable", outStream_tdata, prev_data);
            end
            prev_hold = outStream_tvalid && !outStream_tready;
            prev_data = outStream_tdata;
            if (outStream_tvalid && outStream_tready) begin
                obs_data.push_back(outStream_tdata);
                obs_last.push_back(outStream_tlast);
                obs_dest.push_back(outStream_tdest);
                if (exp_beats.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none", outStream_tdata);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    chk("beat_data", outStream_tdata, b.data);
                    chk("beat_last", outStream_tlast, b.last);
                    chk("beat_dest", outStream_tdest, b.dest);
                    chk("beat_tid", outStream_tid, ACC_ID);
                end
            end
            if (rsp_valid && rsp_ready) begin
                obs_rsp.push_back(rsp_code);
                if (exp_rsp.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rsp: got 0x%0h expected none", rsp_code);
                end else begin
                    chk("rsp_code", rsp_code, exp_rsp.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            outStream_tready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0: return req_ready;
            1: return in_tready;
            2: return ack_tready;
            3: return rsp_valid;
            default: return parent_ready;
        endcase
    endfunction

    task automatic wait_hs(input int which, input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (sig(which)) break;
            n++;
            if (n > LIMIT) begin
                checks++; failures++;
                $display("FAIL timeout_%s: got no handshake expected one within %0d cycles", name, LIMIT);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic load_parent(input logic [63:0] p);
        parent_valid = 1; parent_tid = p;
        wait_hs(4, "parent");
        parent_valid = 0;
        m_ptid = p; m_seq = 0; m_final = 0;
    endtask

    task automatic do_task(input bit deps, input logic [63:0] hdr, input int nwords,
                           input logic [7:0] code, input int ack_beats,
                           input bit with_parent, input logic [63:0] new_ptid);
        bit          is_local;
        logic [4:0]  dest;
        logic [63:0] words[$];
        beat_t       b;
        if (with_parent) begin
            m_ptid = new_ptid; m_seq = 0; m_final = 0;
        end
        dest = deps ? HWR_DEPS_ID : HWR_SCHED_ID;
        for (int i = 0; i < nwords; i++) words.push_back({$urandom, $urandom});
        is_local = m_final || (m_seq == SEQ_MAX);
        if (m_final) begin
            exp_rsp.push_back(ACK_FINAL);
        end else if (m_seq == SEQ_MAX) begin
            exp_rsp.push_back(ACK_REJECT);
        end else begin
            b.dest = dest; b.last = 0;
            b.data = hdr_with_seq(hdr, m_seq); exp_beats.push_back(b);
            b.data = m_ptid;                   exp_beats.push_back(b);
            for (int i = 0; i < nwords; i++) begin
                b.data = words[i]; b.last = (i == nwords - 1); exp_beats.push_back(b);
            end
            if (code == ACK_OK) begin
                exp_rsp.push_back(ACK_OK);
                if (m_seq < SEQ_MAX) m_seq++;
            end else if (code == ACK_FINAL) begin
                exp_rsp.push_back(ACK_FINAL);
                m_final = 1;
            end else begin
                exp_rsp.push_back(ACK_REJECT);
            end
        end

        req_valid = 1; req_deps = deps; req_header = hdr;
        if (with_parent) begin
            parent_valid = 1; parent_tid = new_ptid;
            @(negedge clk);
            chk("req_stalled_by_parent", req_ready, 1'b0);
            chk("parent_ready_idle", parent_ready, 1'b1);
            @(posedge clk); #1;
            parent_valid = 0;
        end
        wait_hs(0, "req");
        req_valid = 0;

        if (is_local) begin
            @(negedge clk);
            chk("local_rsp_latency", rsp_valid, 1'b1);
            @(posedge clk); #1;
        end else begin
            for (int i = 0; i < nwords; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                in_tvalid = 1; in_tdata = words[i]; in_tlast = (i == nwords - 1);
                wait_hs(1, "payload");
                in_tvalid = 0;
            end
            for (int k = 0; k < ack_beats; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                ack_tvalid = 1;
                ack_tdata  = (k == 0) ? {$urandom, $urandom_range(0, 16777215), code}[63:0]
                                      : {$urandom, $urandom};
                ack_tlast  = (k == ack_beats - 1);
                wait_hs(2, "ack");
                ack_tvalid = 0; ack_tlast = 0;
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        rsp_ready = 1;
        wait_hs(3, "rsp");
        rsp_ready = 0;
        @(negedge clk);
        chk("final_mode", final_mode, m_final);
        chk("ack_tready_idle", ack_tready, 1'b0);
        chk("in_tready_idle", in_tready, 1'b0);
        chk("beats_drained", exp_beats.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        int nrsp;
        int code_sel;
        logic [7:0] code;
        beat_t b;

        #3;
        chk("rst_tvalid", outStream_tvalid, 1'b0);
        chk("rst_parent_ready", parent_ready, 1'b0);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_in_tready", in_tready, 1'b0);
        chk("rst_ack_tready", ack_tready, 1'b0);
        chk("rst_final_mode", final_mode, 1'b0);
        repeat (2) tick();
        rstn = 1;
        tick();

        // Parent 0x55, deps request, 2 words, ack OK; then next header carries seq 1
        load_parent(64'h55);
        base = obs_data.size();
        do_task(1, 64'h1122_33FF_4455_6677, 2, ACK_OK, 1, 0, 0);
        chk("lit_header_seq0", obs_data[base], 64'h1122_3300_4455_6677);
        chk("lit_ptid", obs_data[base + 1], 64'h55);
        chk("lit_last_on_w1", obs_last[base + 3], 1'b1);
        chk("lit_dest_deps", obs_dest[base], HWR_DEPS_ID);
        chk("lit_beat_count", obs_data.size() - base, 4);
        chk("lit_rsp_ok", obs_rsp[obs_rsp.size() - 1], ACK_OK);
        base = obs_data.size();
        do_task(0, 64'h0, 1, ACK_OK, 1, 0, 0);
        chk("lit_header_seq1", obs_data[base], 64'h0000_0001_0000_0000);
        chk("lit_dest_sched", obs_dest[base], HWR_SCHED_ID);

        // Stray acks while idle are not consumed
        ack_tvalid = 1; ack_tdata = 64'(ACK_FINAL); ack_tlast = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ack_ignored_idle", ack_tready, 1'b0);
            @(posedge clk); #1;
        end
        ack_tvalid = 0; ack_tlast = 0;

        // Unknown code -> REJECT, counter unchanged
        do_task(0, 64'h0, 1, 8'h7E, 1, 0, 0);
        chk("lit_rsp_reject", obs_rsp[obs_rsp.size() - 1], ACK_REJECT);
        base = obs_data.size();
        do_task(0, 64'h0, 1, ACK_FINAL, 1, 0, 0);
        chk("lit_seq_after_reject", obs_data[base], 64'h0000_0002_0000_0000);
        chk("lit_rsp_final", obs_rsp[obs_rsp.size() - 1], ACK_FINAL);
        chk("lit_final_mode_set", final_mode, 1'b1);
        base = obs_data.size();
        do_task(1, 64'h0, 2, ACK_OK, 1, 0, 0);
        chk("lit_final_no_beats", obs_data.size() - base, 0);
        chk("lit_local_final", obs_rsp[obs_rsp.size() - 1], ACK_FINAL);
        load_parent(64'hABCD);
        chk("lit_final_cleared", final_mode, 1'b0);

        // Parent and request together; then fill counter; 3-beat ack at seq 6
        base = obs_data.size();
        do_task(0, 64'h0, 1, ACK_OK, 1, 1, 64'h99);
        chk("lit_parent_first_seq0", obs_data[base], 64'h0);
        chk("lit_parent_first_ptid", obs_data[base + 1], 64'h99);
        for (int i = 0; i < 5; i++) do_task(0, 64'h0, 1, ACK_OK, 1, 0, 0);
        base = obs_data.size();
        do_task(0, 64'h0, 1, ACK_OK, 3, 0, 0);
        chk("lit_seq6", obs_data[base], 64'h0000_0006_0000_0000);
        chk("lit_3beat_ok", obs_rsp[obs_rsp.size() - 1], ACK_OK);
        base = obs_data.size();
        nrsp = obs_rsp.size();
        do_task(0, 64'h0, 1, ACK_OK, 1, 0, 0);
        chk("lit_sat_no_beats", obs_data.size() - base, 0);
        chk("lit_sat_reject", obs_rsp[nrsp], ACK_REJECT);

        // Randomized traffic with backpressure and gaps
        rnd_ready = 1;
        for (int t = 0; t < 40; t++) begin
            code_sel = $urandom_range(0, 9);
            if (code_sel < 6)       code = ACK_OK;
            else if (code_sel == 6) code = ACK_FINAL;
            else if (code_sel == 7) code = ACK_REJECT;
            else                    code = 8'($urandom_range(0, 255));
            do_task($urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(1, 4), code,
                    $urandom_range(1, 3), ($urandom_range(0, 5) == 0), {$urandom, $urandom});
        end

        // Reset in the middle of the payload abandons the message
        rnd_ready = 0;
        load_parent(64'h77);
        b.dest = HWR_SCHED_ID; b.last = 0;
        b.data = hdr_with_seq(64'h0, m_seq); exp_beats.push_back(b);
        b.data = m_ptid;                     exp_beats.push_back(b);
        b.data = 64'hDEAD_BEEF;              exp_beats.push_back(b);
        req_valid = 1; req_deps = 0; req_header = 64'h0;
        wait_hs(0, "req_rst");
        req_valid = 0;
        in_tvalid = 1; in_tdata = 64'hDEAD_BEEF; in_tlast = 0;
        wait_hs(1, "payload_rst");
        in_tvalid = 0;
        #2 rstn = 0;
        #1;
        chk("midrst_tvalid", outStream_tvalid, 1'b0);
        chk("midrst_tlast", outStream_tlast, 1'b0);
        chk("midrst_in_tready", in_tready, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_parent_ready", parent_ready, 1'b0);
        chk("midrst_beats_seen", exp_beats.size(), 0);
        exp_beats.delete();
        m_seq = 0; m_final = 0; m_ptid = '0;
        tick(); tick();
        #2 rstn = 1;
        tick();
        base = obs_data.size();
        do_task(0, 64'hFFFF_FFFF_FFFF_FFFF, 1, ACK_OK, 1, 0, 0);
        chk("lit_post_rst_seq0", obs_data[base], 64'hFFFF_FF00_FFFF_FFFF);
        chk("lit_post_rst_ptid0", obs_data[base + 1], 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/new_task_sender.md
NEW_TASK_SENDER -- requirements
Module: New_Task_Sender

Interface
REQ-001 SHALL have parameters: ACC_BITS, default 4, accelerator id width; ACC_ID, default 0, this accelerator's id driven on outStream_tid; SEQ_BITS, default TASK_SEQ_ID_H-TASK_SEQ_ID_L+1, sequence counter width.
REQ-002 SHALL have ports: clk in 1 clock; rstn in 1 async active-low reset; parent_valid in 1 load new parent; parent_ready out 1; parent_tid in 64 parent task id; req_valid in 1 task request; req_ready out 1; req_deps in 1 task has dependences; req_header in 64 header fields other than seq id; in_tvalid in 1; in_tready out 1; in_tdata in 64 payload; in_tlast in 1; outStream_tvalid out 1; outStream_tready in 1; outStream_tdata out 64; outStream_tlast out 1; outStream_tid out ACC_BITS; outStream_tdest out 5; ack_tvalid in 1; ack_tready out 1; ack_tdata in 64; ack_tlast in 1; rsp_valid out 1; rsp_ready in 1; rsp_code out 8 (ACK_OK/REJECT/FINAL code); final_mode out 1.

Function
REQ-003 SHALL be the accelerator-side initiator of the new-task protocol: send one request message, then wait for exactly one ack message.
REQ-004 SHALL use states IDLE, HEADER, PTID, PAYLOAD, WAIT_ACK, RESPOND.
REQ-005 IDLE: parent_ready=1, req_ready=1; parent_valid has priority over req_valid in the same cycle (parent loaded, request not accepted).
REQ-006 parent load: store parent_tid, clear seq counter to 0, clear final_mode.
REQ-007 request accepted in IDLE: latch req_deps/req_header; if final_mode=1 or seq counter saturated -> RESPOND with FINAL (final_mode) or REJECT (saturated), no outStream beat; else -> HEADER.
REQ-008 HEADER: outStream_tdata = req_header with [TASK_SEQ_ID_H:TASK_SEQ_ID_L] = seq counter, tlast=0; on tready -> PTID.
REQ-009 PTID: outStream_tdata = parent tid, tlast=0; on tready -> PAYLOAD.
REQ-010 PAYLOAD: combinational pass-through, outStream_tvalid=in_tvalid, in_tready=outStream_tready, tdata/tlast from in_*; beat with tlast and tready -> WAIT_ACK.
REQ-011 outStream_tdest = HWR_DEPS_ID if latched deps else HWR_SCHED_ID; outStream_tid = ACC_ID constant; both stable for whole message.
REQ-012 outStream_tvalid SHALL NOT drop once asserted until tready; no bubbles inserted by the block in HEADER/PTID.
REQ-013 WAIT_ACK: ack_tready=1; code = ack_tdata[7:0] of first beat; beats until ack_tlast consumed; after tlast beat -> RESPOND.
REQ-014 code ACK_OK: seq counter +1; ACK_FINAL: final_mode<=1, counter unchanged; ACK_REJECT or any unknown code: reported as REJECT, counter unchanged.
REQ-015 RESPOND: rsp_valid=1, rsp_code held; on rsp_ready -> IDLE. Minimum local-response latency 1 cycle after accept.
REQ-016 seq counter saturates at all-ones; never wraps to 0 (0 reserved for first task of parent).
REQ-017 ack_tvalid outside WAIT_ACK SHALL be ignored (ack_tready=0).
REQ-018 in_tready=0 outside PAYLOAD.

Reset
REQ-019 rstn low asynchronously: state IDLE, seq counter 0, final_mode 0, parent tid 0, all valid/ready outputs 0 except parent_ready/req_ready which become 1 after release; mid-message reset abandons message (no tlast sent).

Structure
REQ-020 Ack codes, HWR_DEPS_ID, HWR_SCHED_ID, TASK_SEQ_ID_H/L SHALL come from package OmpSsManager; state enum local.
REQ-021 Single module, no sub-modules.

Verification
REQ-022 parent 0x55, deps request, 2 payload words, ack OK -> beats: header seq 0, 0x55, w0, w1 (tlast), tdest HWR_DEPS_ID; rsp OK; next header seq 1.
REQ-023 ack FINAL -> rsp FINAL, final_mode=1; next request answered FINAL 1 cycle later, zero outStream beats; parent reload clears final_mode.
REQ-024 ack code 0x7E -> rsp REJECT, counter unchanged.
REQ-025 outStream_tready toggled randomly, in_tvalid gaps -> data order/tvalid stability preserved, no lost beats.
REQ-026 parent_valid and req_valid same cycle -> parent loaded, request stalled one cycle; rstn pulse in PAYLOAD -> IDLE, counter 0.
REQ-027 3-beat ack, counter at max -> first-beat code used; saturated counter gives local REJECT.
